// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the MIPS pipeline: RegDst and PCSrc encodings,
// opcode constants and the control-word bundle that travels from decode
// through ID/EX, EX/MEM and MEM/WB.
package id_ex_stage_pkg;

    // Destination register select driven by the control unit
    typedef enum logic [1:0] {
        RD_RA   = 2'b00,   // jal writes the return-address register
        RD_RT   = 2'b01,   // I-type writes rt
        RD_RD   = 2'b10,   // R-type writes rd
        RD_NONE = 2'b11    // no architectural destination
    } regdst_e;

    // Next-PC select driven by the control unit
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00, // PC + 4
        PC_BRANCH = 2'b01, // PC + 4 + (imm << 2)
        PC_JUMP   = 2'b10, // {PC[31:28], target, 2'b00}
        PC_JR     = 2'b11  // register target
    } pcsrc_e;

    // Primary opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Control word carried down the pipeline after RegDst has been resolved
    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_rw;
        logic       alu_src;
        logic       extnum;
        logic       wr_reg_data;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
    } ctrl_t;

    // A bubble carries no side effects at all
    localparam ctrl_t CTRL_NOP = '0;

    // rt is a true source unless the ALU takes the immediate; stores read
    // rt as the write data even though ALUSrc selects the immediate.
    function automatic logic uses_rt(input logic alu_src, input logic mem_rw);
        return (~alu_src) | mem_rw;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check between the instruction in ID and the registered
// instruction in EX. Purely combinational so it can be reused for
// forwarding comparisons.
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_alu_src,
    input  logic              id_mem_rw,
    input  logic              ex_valid,
    input  logic              ex_memto_reg,
    input  logic [REG_AW-1:0] ex_wreg,
    output logic              hazard
);

    logic rt_used;
    logic rs_match;
    logic rt_match;
    logic ex_is_load;

    // Compare ID sources against a pending load destination; $0 never matches
    always_comb begin
        rt_used    = uses_rt(id_alu_src, id_mem_rw);
        ex_is_load = ex_valid & ex_memto_reg & (ex_wreg != '0);
        rs_match   = (ex_wreg == id_rs);
        rt_match   = rt_used & (ex_wreg == id_rt);
        hazard     = id_valid & ex_is_load & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core. Captures the decoded
// control word, operands and register fields, resolves the destination
// register, inserts bubbles for flushes and load-use hazards, and counts
// stall cycles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int RA_ADDR = 31,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_MemRW,
    input  logic              id_ALUSrc,
    input  logic              id_Extnum,
    input  logic              id_WrRegData,
    input  logic [3:0]        id_ALUControl,
    input  logic [1:0]        id_PCSrc,
    input  logic [1:0]        id_RegDst,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemtoReg,
    output logic              ex_MemRW,
    output logic              ex_ALUSrc,
    output logic              ex_Extnum,
    output logic              ex_WrRegData,
    output logic [3:0]        ex_ALUControl,
    output logic [1:0]        ex_PCSrc,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [4:0]        ex_shamt,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Registered EX state
    logic              valid_q,     valid_d;
    ctrl_t             ctrl_q,      ctrl_d;
    logic [DATA_W-1:0] pc4_q,       pc4_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [REG_AW-1:0] rs_q,        rs_d;
    logic [REG_AW-1:0] rt_q,        rt_d;
    logic [REG_AW-1:0] wreg_q,      wreg_d;
    logic [4:0]        shamt_q,     shamt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    ctrl_t             id_ctrl;
    logic [REG_AW-1:0] id_wreg;
    logic              hazard;
    logic              bubble;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_alu_src   (id_ALUSrc),
        .id_mem_rw    (id_MemRW),
        .ex_valid     (valid_q),
        .ex_memto_reg (ctrl_q.memto_reg),
        .ex_wreg      (wreg_q),
        .hazard       (hazard)
    );

    // A flush squashes the ID instruction, so it must not also hold upstream
    assign stall = hazard & ~flush;

    // Bundle the control unit outputs and resolve the destination register
    always_comb begin
        id_ctrl             = CTRL_NOP;
        id_ctrl.reg_write   = id_RegWrite;
        id_ctrl.memto_reg   = id_MemtoReg;
        id_ctrl.mem_rw      = id_MemRW;
        id_ctrl.alu_src     = id_ALUSrc;
        id_ctrl.extnum      = id_Extnum;
        id_ctrl.wr_reg_data = id_WrRegData;
        id_ctrl.alu_control = id_ALUControl;
        id_ctrl.pc_src      = id_PCSrc;

        unique case (regdst_e'(id_RegDst))
            RD_RA:   id_wreg = REG_AW'(RA_ADDR);
            RD_RT:   id_wreg = id_rt;
            RD_RD:   id_wreg = id_rd;
            default: id_wreg = '0;
        endcase
    end

    // Next EX state: flush and hazard both load a bubble; otherwise capture ID.
    // An invalid ID slot is also a bubble because the control unit asserts
    // RegWrite for unused opcodes.
    always_comb begin
        bubble      = flush | hazard | ~id_valid;

        valid_d     = 1'b0;
        ctrl_d      = CTRL_NOP;
        if (!bubble) begin
            valid_d = 1'b1;
            ctrl_d  = id_ctrl;
        end

        // Data fields carry no side effects, so they are captured every edge
        pc4_d       = id_pc4;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        rs_d        = id_rs;
        rt_d        = id_rt;
        wreg_d      = id_wreg;
        shamt_d     = id_shamt;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            pc4_q       <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            wreg_q      <= '0;
            shamt_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc4_q       <= pc4_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            wreg_q      <= wreg_d;
            shamt_q     <= shamt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_RegWrite   = ctrl_q.reg_write;
    assign ex_MemtoReg   = ctrl_q.memto_reg;
    assign ex_MemRW      = ctrl_q.mem_rw;
    assign ex_ALUSrc     = ctrl_q.alu_src;
    assign ex_Extnum     = ctrl_q.extnum;
    assign ex_WrRegData  = ctrl_q.wr_reg_data;
    assign ex_ALUControl = ctrl_q.alu_control;
    assign ex_PCSrc      = ctrl_q.pc_src;
    assign ex_pc4        = pc4_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_wreg       = wreg_q;
    assign ex_shamt      = shamt_q;
    assign stall_count   = stall_cnt_q;

endmodule
